// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered output stage behind the ALU logic-result mux. Each accepted
// result is sanitised, tagged with status flags at capture time and queued
// in a 2-entry skid FIFO toward a valid/ready consumer. A saturating counter
// records how many results were accepted with the unused select code.
module alu_result_stage #(
   parameter int WIDTH     = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_result,
   input  logic [1:0]           in_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic                 out_zero,
   output logic                 out_neg,
   output logic                 out_parity,
   output logic                 out_undef,
   output logic [ERR_CNT_W-1:0] err_count
);

   // Entry layout: {result, zero, neg, parity, undef}
   localparam int ENT_W = WIDTH + 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                 state_p1;
   state_t                 state_nxt;
   logic [ENT_W-1:0]       cap_p0;
   logic [ENT_W-1:0]       head_p1;
   logic [ENT_W-1:0]       tail_p1;
   logic [ERR_CNT_W-1:0]   err_cnt_p1;
   logic                   push;
   logic                   pop;
   logic                   load_head;
   logic                   load_tail;
   logic                   shift_tail;
   logic                   undef_push;

   // Select 3 routes the mux's unconnected input, so its data is replaced by
   // a fixed zero entry; this also keeps an X on in_result out of the FIFO.
   function automatic logic [ENT_W-1:0] sanitize(input logic [WIDTH-1:0] r,
                                                 input logic [1:0]       sel);
      logic [ENT_W-1:0] e;
      if (sel == 2'd3) begin
         e = {{WIDTH{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b1};
      end else begin
         e = {r, (r == '0), r[WIDTH-1], ^r, 1'b0};
      end
      return e;
   endfunction

   // Counter sticks at all-ones instead of wrapping.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      logic [ERR_CNT_W-1:0] n;
      if (c == '1) begin
         n = c;
      end else begin
         n = c + 1'b1;
      end
      return n;
   endfunction

   // Handshake decode from registered occupancy only, so in_ready never
   // follows out_ready combinationally.
   assign in_ready   = (state_p1 != FULL);
   assign out_valid  = (state_p1 != EMPTY);
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign undef_push = push && (in_sel == 2'd3);

   // ---- p0: capture-side sanitising and flag derivation ----
   assign cap_p0 = sanitize(in_result, in_sel);

   // Occupancy next-state and entry load steering.
   always_comb begin
      state_nxt  = state_p1;
      load_head  = 1'b0;
      load_tail  = 1'b0;
      shift_tail = 1'b0;
      unique case (state_p1)
         EMPTY: begin
            if (push) begin
               state_nxt = ONE;
               load_head = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               load_head = 1'b1;
            end else if (push) begin
               state_nxt = FULL;
               load_tail = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt  = ONE;
               shift_tail = 1'b1;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   // ---- p1: occupancy state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= EMPTY;
      end else begin
         state_p1 <= state_nxt;
      end
   end

   // Head entry: new capture when the FIFO drains to it, else the tail moves up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_p1 <= '0;
      end else if (load_head) begin
         head_p1 <= cap_p0;
      end else if (shift_tail) begin
         head_p1 <= tail_p1;
      end
   end

   // Tail entry: skid slot filled only when the head is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tail_p1 <= '0;
      end else if (load_tail) begin
         tail_p1 <= cap_p0;
      end
   end

   // Undefined-select counter advances on accepted sel==3 transfers only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_p1 <= '0;
      end else if (undef_push) begin
         err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
   end

   assign out_result = head_p1[ENT_W-1:4];
   assign out_zero   = head_p1[3];
   assign out_neg    = head_p1[2];
   assign out_parity = head_p1[1];
   assign out_undef  = head_p1[0];
   assign err_count  = err_cnt_p1;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage (2-bit error counter instance).
module tb_alu_result_stage;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_result;
   logic [1:0] in_sel;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_zero;
   logic       out_neg;
   logic       out_parity;
   logic       out_undef;
   logic [1:0] err_count;

   int n_cmp;
   int n_err;

   alu_result_stage #(.WIDTH(8), .ERR_CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_sel     (in_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_parity (out_parity),
      .out_undef  (out_undef),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [7:0] r,
                           input logic z, input logic n, input logic p, input logic u);
      chk8({tag, "_result"}, out_result, r);
      chk1({tag, "_zero"},   out_zero,   z);
      chk1({tag, "_neg"},    out_neg,    n);
      chk1({tag, "_parity"}, out_parity, p);
      chk1({tag, "_undef"},  out_undef,  u);
   endtask

   logic [7:0] vals [20];
   logic [7:0] v;
   logic [1:0] sat_exp [5];

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_result = 8'h00;
      in_sel    = 2'd0;
      out_ready = 1'b0;
      sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
      sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

      // Reset state
      #12;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_in_ready",  in_ready,  1'b1);
      chk2("rst_err_count", err_count, 2'd0);
      chk_head("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;

      // Single pass: 0x80 with sel 1, consumer ready
      in_valid  = 1'b1;
      in_result = 8'h80;
      in_sel    = 2'd1;
      out_ready = 1'b1;
      step();
      chk1("single_out_valid", out_valid, 1'b1);
      chk1("single_in_ready",  in_ready,  1'b1);
      chk_head("single", 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
      in_valid = 1'b0;
      step();
      chk1("single_popped", out_valid, 1'b0);

      // Back-pressure: 0x00, 0x0F accepted, 0x55 held off
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 8'h00;
      in_sel    = 2'd0;
      step();
      chk1("bp1_in_ready", in_ready, 1'b1);
      chk_head("bp1", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      in_result = 8'h0F;
      in_sel    = 2'd2;
      step();
      chk1("bp2_in_ready",  in_ready,  1'b0);
      chk1("bp2_out_valid", out_valid, 1'b1);
      chk8("bp2_head_stable", out_result, 8'h00);
      in_result = 8'h55;
      in_sel    = 2'd0;
      step();
      chk1("bp3_in_ready", in_ready, 1'b0);
      chk8("bp3_head_stable", out_result, 8'h00);
      step();
      chk1("bp4_in_ready", in_ready, 1'b0);
      chk1("bp4_zero", out_zero, 1'b1);
      out_ready = 1'b1;
      step();
      chk1("bp5_in_ready", in_ready, 1'b1);
      chk_head("bp5", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk1("bp6_out_valid", out_valid, 1'b1);
      chk_head("bp6", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      step();
      chk1("bp7_drained", out_valid, 1'b0);

      // Streaming: one result per cycle through the ONE state
      for (int i = 0; i < 20; i++) vals[i] = 8'($urandom);
      vals[3] = 8'h00;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid  = 1'b1;
         in_result = vals[i];
         in_sel    = 2'($urandom_range(0, 2));
         step();
         v = vals[i];
         chk1("stream_in_ready",  in_ready,  1'b1);
         chk1("stream_out_valid", out_valid, 1'b1);
         chk_head("stream", v, (v == 8'h00), v[7], ^v, 1'b0);
      end
      in_valid = 1'b0;
      step();
      chk1("stream_drained", out_valid, 1'b0);
      chk2("stream_err_count", err_count, 2'd0);

      // Undefined select with X data
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 'x;
      in_sel    = 2'd3;
      step();
      chk_head("undef", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      chk2("undef_err_count", err_count, 2'd1);
      in_valid  = 1'b0;
      in_sel    = 'x;
      out_ready = 1'b1;
      step();
      chk1("undef_popped", out_valid, 1'b0);
      chk2("undef_cnt_hold_on_pop", err_count, 2'd1);
      chk1("undef_in_ready_known", in_ready, 1'b1);

      // Fill both entries, then reset asynchronously mid-cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 8'hC3;
      in_sel    = 2'd3;
      step();
      in_result = 8'h7E;
      in_sel    = 2'd1;
      step();
      chk1("full_in_ready", in_ready, 1'b0);
      chk2("full_err_count", err_count, 2'd2);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk1("arst_out_valid", out_valid, 1'b0);
      chk1("arst_in_ready",  in_ready,  1'b1);
      chk2("arst_err_count", err_count, 2'd0);
      chk_head("arst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      #3;
      rst_n = 1'b1;
      #1;
      chk1("rel_no_stale", out_valid, 1'b0);

      // Saturation: five sel==3 pushes, first on the first edge after release
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_result = 8'hA5;
      in_sel    = 2'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         chk2("sat_err_count", err_count, sat_exp[i]);
         chk1("sat_undef", out_undef, 1'b1);
      end
      in_result = 8'h3C;
      in_sel    = 2'd0;
      step();
      chk2("sat_hold_sel0", err_count, 2'd3);
      chk_head("sat_sel0", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      step();
      chk1("final_drained", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
